// File: rtl/hazard_pkg.sv
// Shared constants, slot record and small helpers for the MIPS pipeline hazard scoreboard.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_0   = 2'd0;
  localparam logic [1:0] TUSE_1   = 2'd1;
  localparam logic [1:0] TUSE_2   = 2'd2;

  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LINK = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FSEL_RF    = 2'd0;
  localparam logic [1:0] FSEL_M_ALU = 2'd1;
  localparam logic [1:0] FSEL_M_PC8 = 2'd2;
  localparam logic [1:0] FSEL_W     = 2'd3;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LINK = 2'd1,
    KIND_LOAD = 2'd2
  } kind_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    kind_e      kind;
    logic [4:0] rs;
    logic [4:0] rt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dst: 5'd0, tnew: 2'd0,
                                   kind: KIND_ALU, rs: 5'd0, rt: 5'd0};

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A producer blocks a reader when its value arrives later than the reader's deadline.
  function automatic logic slot_blocks(input logic v, input logic [4:0] dst,
                                       input logic [1:0] tnew, input logic has,
                                       input logic [4:0] src, input logic [1:0] tuse);
    return v && has && (dst != 5'd0) && (dst == src) && (tnew > tuse);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_valid, input logic [4:0] m_dst,
                                         input logic [1:0] m_tnew, input kind_e m_kind,
                                         input logic w_valid, input logic [4:0] w_dst,
                                         input logic [4:0] src);
    if (src == 5'd0) return FSEL_RF;
    if (m_valid && (m_dst == src) && (m_tnew == 2'd0))
      return (m_kind == KIND_LINK) ? FSEL_M_PC8 : FSEL_M_ALU;
    if (w_valid && (w_dst == src)) return FSEL_W;
    return FSEL_RF;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of one instruction into destination, read deadlines and result latency.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_dst,
  output logic        o_has_rs,
  output logic        o_has_rt,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic [1:0]  o_tnew,
  output logic [1:0]  o_kind
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_fn     = i_instr[5:0];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

  always_comb begin
    o_dst     = '0;
    o_has_rs  = 1'b0;
    o_has_rt  = 1'b0;
    o_tuse_rs = TUSE_0;
    o_tuse_rt = TUSE_0;
    o_tnew    = '0;
    o_kind    = KIND_ALU;
    case (w_op)
      OP_RTYPE: begin
        if (w_fn == FN_ADDU || w_fn == FN_SUBU) begin
          o_dst     = w_rd;
          o_has_rs  = 1'b1;
          o_has_rt  = 1'b1;
          o_tuse_rs = TUSE_1;
          o_tuse_rt = TUSE_1;
          o_tnew    = TNEW_ALU;
        end else if (w_fn == FN_JR) begin
          o_has_rs  = 1'b1;
          o_tuse_rs = TUSE_0;
        end
      end
      OP_ORI: begin
        o_dst     = w_rt;
        o_has_rs  = 1'b1;
        o_tuse_rs = TUSE_1;
        o_tnew    = TNEW_ALU;
      end
      OP_LUI: begin
        o_dst  = w_rt;
        o_tnew = TNEW_ALU;
      end
      OP_LW: begin
        o_dst     = w_rt;
        o_has_rs  = 1'b1;
        o_tuse_rs = TUSE_1;
        o_tnew    = TNEW_LOAD;
        o_kind    = KIND_LOAD;
      end
      OP_SW: begin
        o_has_rs  = 1'b1;
        o_has_rt  = 1'b1;
        o_tuse_rs = TUSE_1;
        o_tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        o_has_rs  = 1'b1;
        o_has_rt  = 1'b1;
        o_tuse_rs = TUSE_0;
        o_tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        o_dst  = 5'd31;
        o_tnew = TNEW_LINK;
        o_kind = KIND_LINK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow E/M/W writer pipeline with Tuse/Tnew stall detection, bypass selects and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  output logic             stall,
  output logic             flush_e,
  output logic [1:0]       fsel_d_rs,
  output logic [1:0]       fsel_d_rt,
  output logic [1:0]       fsel_e_rs,
  output logic [1:0]       fsel_e_rt,
  output logic [1:0]       fsel_m_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       w_dst;
  logic             w_has_rs;
  logic             w_has_rt;
  logic [1:0]       w_tuse_rs;
  logic [1:0]       w_tuse_rt;
  logic [1:0]       w_tnew;
  logic [1:0]       w_kind;
  logic [4:0]       w_id_rs;
  logic [4:0]       w_id_rt;
  logic             w_stall;
  logic             w_unused;
  slot_t            w_slot_id;
  slot_t            w_slot_m_next;
  slot_t            w_slot_w_next;
  slot_t            r_slot_e;
  slot_t            r_slot_m;
  slot_t            r_slot_w;
  logic [CNT_W-1:0] r_stall_cnt;

  hazard_decode u_decode (
    .i_instr   (id_instr),
    .o_dst     (w_dst),
    .o_has_rs  (w_has_rs),
    .o_has_rt  (w_has_rt),
    .o_tuse_rs (w_tuse_rs),
    .o_tuse_rt (w_tuse_rt),
    .o_tnew    (w_tnew),
    .o_kind    (w_kind)
  );

  assign w_id_rs  = id_instr[25:21];
  assign w_id_rt  = id_instr[20:16];
  assign w_unused = ^{r_slot_w.kind, r_slot_w.rs, r_slot_w.rt};

  always_comb begin
    w_slot_id = '{valid: 1'b1, dst: w_dst, tnew: w_tnew, kind: kind_e'(w_kind),
                  rs: w_id_rs, rt: w_id_rt};
    w_slot_m_next      = r_slot_e;
    w_slot_m_next.tnew = tnew_dec(r_slot_e.tnew);
    w_slot_w_next      = r_slot_m;
    w_slot_w_next.tnew = tnew_dec(r_slot_m.tnew);
  end

  always_comb begin
    w_stall = 1'b0;
    if (slot_blocks(r_slot_e.valid, r_slot_e.dst, r_slot_e.tnew, w_has_rs, w_id_rs, w_tuse_rs) ||
        slot_blocks(r_slot_e.valid, r_slot_e.dst, r_slot_e.tnew, w_has_rt, w_id_rt, w_tuse_rt) ||
        slot_blocks(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, w_has_rs, w_id_rs, w_tuse_rs) ||
        slot_blocks(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, w_has_rt, w_id_rt, w_tuse_rt) ||
        slot_blocks(r_slot_w.valid, r_slot_w.dst, r_slot_w.tnew, w_has_rs, w_id_rs, w_tuse_rs) ||
        slot_blocks(r_slot_w.valid, r_slot_w.dst, r_slot_w.tnew, w_has_rt, w_id_rt, w_tuse_rt))
      w_stall = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_e    <= SLOT_EMPTY;
      r_slot_m    <= SLOT_EMPTY;
      r_slot_w    <= SLOT_EMPTY;
      r_stall_cnt <= '0;
    end else begin
      r_slot_w <= w_slot_w_next;
      r_slot_m <= w_slot_m_next;
      r_slot_e <= w_stall ? SLOT_EMPTY : w_slot_id;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall     = w_stall;
  assign flush_e   = w_stall;
  assign stall_cnt = r_stall_cnt;

  assign fsel_d_rs = fwd_sel(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, r_slot_m.kind,
                             r_slot_w.valid, r_slot_w.dst, w_id_rs);
  assign fsel_d_rt = fwd_sel(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, r_slot_m.kind,
                             r_slot_w.valid, r_slot_w.dst, w_id_rt);
  assign fsel_e_rs = fwd_sel(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, r_slot_m.kind,
                             r_slot_w.valid, r_slot_w.dst, r_slot_e.rs);
  assign fsel_e_rt = fwd_sel(r_slot_m.valid, r_slot_m.dst, r_slot_m.tnew, r_slot_m.kind,
                             r_slot_w.valid, r_slot_w.dst, r_slot_e.rt);

  // Store data in M only ever needs the W write-back value; M/E results are already in-pipe.
  assign fsel_m_rt = (r_slot_m.valid && r_slot_w.valid && (r_slot_w.dst != 5'd0) &&
                      (r_slot_w.dst == r_slot_m.rt)) ? FSEL_W : FSEL_RF;

endmodule
